grad_accum: RTL and testbench
=============================

# grad_accum

Sequential gradient accumulator and weight-update stage for the fixed-point backprop datapath. It sits directly downstream of the 3-input multiplier, which produces one signed Q(WIDTH-FRAC).FRAC gradient term per cycle (delta × learning-rate × activation). It accepts exactly N such terms over a valid/ready handshake and sums them at extended precision. It then produces the saturated updated weight w_new = w − Σterms and holds it until acknowledged.

## Interface
- WIDTH, 32, data word width (signed two's complement)
- FRAC, 24, fractional bits; shared by all data ports, so no rescaling is required
- N, 4, number of terms per update; legal range 1..255
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset; one clock, asynchronous and active-low
- i_start  in  1  starts an update; sampled only in IDLE
- i_w  in  WIDTH  current weight; latched when i_start is accepted
- i_valid  in  1  i_term is valid
- i_term  in  WIDTH  gradient term from the multiplier stage
- o_ready  out  1  block accepts a term this cycle
- o_valid  out  1  o_w/o_sat hold a new result
- i_ack  in  1  consumer takes the result
- o_w  out  WIDTH  updated weight, saturated
- o_sat  out  1  result was clipped
- o_busy  out  1  state ≠ IDLE

## Operation
- Internal widths:
  - CNTW = clog2(N+1).
  - Accumulator is ACCW = WIDTH+CNTW+1 bits signed.
  - Terms and weight are sign-extended to ACCW.
  - No overflow is possible inside the accumulator.
- States and transitions:
  - IDLE: i_start=1 → latch i_w, clear acc and cnt, go to ACC.
  - ACC:
    - o_ready=1.
    - Each edge with i_valid&o_ready adds i_term to acc and increments cnt.
    - When the accepted term is the Nth (cnt==N−1 before the increment), go to CALC.
  - CALC:
    - Compute diff = w_ext − acc.
    - If diff > 2^(WIDTH−1)−1: o_w=max, o_sat=1.
    - If diff < −2^(WIDTH−1): o_w=min, o_sat=1.
    - Otherwise: o_w=diff[WIDTH−1:0], o_sat=0.
    - Go to DONE.
  - DONE: o_valid=1; edge with i_ack=1 → IDLE.
- Signal qualification by state:
  - i_start is ignored outside IDLE.
  - i_valid is ignored outside ACC; terms presented then are dropped, not queued.
  - i_ack is ignored outside DONE.
- o_w and o_sat are registered. They keep their last value after ack until the next CALC overwrites them.
- o_ready, o_valid and o_busy are decoded from the state register (Moore outputs).
- Reset (any time, including mid-ACC):
  - State returns to IDLE.
  - acc, cnt, latched w, o_w and o_sat are cleared to 0.
  - o_ready, o_valid and o_busy are 0.
  - No partial result is emitted.

## Timing
- Reset values: o_ready=0, o_valid=0, o_w=0, o_sat=0, o_busy=0.
- Start:
  - i_start is sampled high at edge E0.
  - o_busy and o_ready are high from E0.
  - The first term can be accepted at E1.
- Latency: Nth term accepted at edge Ek → CALC during cycle Ek..Ek+1 → o_valid high from Ek+1.
- Minimum update time is N+2 cycles from start to o_valid. This assumes i_valid is held high.
- Gaps in i_valid stall the block with no penalty, and cnt is unchanged during a gap.
- DONE holds indefinitely until i_ack; o_w is stable while o_valid=1.
- i_ack at edge Ea → IDLE from Ea. i_start is sampled again from Ea+1, so back-to-back updates take N+3 cycles.
- A term offered in the same cycle as o_ready's final high cycle is accepted only if it is the Nth. o_ready is low in CALC.
- N=1: ACC → CALC after a single accept.

## Test plan
- Nominal:
  - Stimulus: N=4, i_w=0x01000000 (1.0), four terms 0x00400000 (0.25), i_valid held high.
  - Required: o_w=0x00000000, o_sat=0, o_valid rising exactly 6 cycles after the start edge.
- Positive saturation:
  - Stimulus: i_w=0x7F000000 (127.0), four terms 0x9C000000 (−100.0); raw result 527.0.
  - Required: o_w=0x7FFFFFFF, o_sat=1.
- Negative saturation:
  - Stimulus: i_w=0x80000000 (−128.0), four terms 0x01000000.
  - Required: o_w=0x80000000, o_sat=1.
  - Then i_w=0x80000000 with terms 0xFF000000 (−1.0) → o_w=0x84000000, o_sat=0.
- Handshake gaps:
  - Stimulus: i_valid pattern 1,0,0,1,1,0,1,1 with terms 1..8 (LSB units), i_w=0. Also pulse i_start and i_ack during ACC.
  - Required: only the terms presented with i_valid=1 are accepted, namely values 1,4,5,7, giving o_w=−17=0xFFFFFFEF. The i_start and i_ack pulses during ACC have no effect.
- Hold and back-to-back:
  - Stimulus: withhold i_ack for 10 cycles, then assert i_ack together with i_start.
  - Required: o_w stable and o_valid high throughout the hold. i_start in the ack cycle is ignored, and an i_start one cycle later begins a new update.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously (between edges) after 2 accepted terms, then restart with i_w=0x01000000 and four 0x00400000 terms.
  - Required: all outputs go to 0 immediately. The restarted update yields o_w=0, with no carry-over of the earlier partial sum.

Source files
------------

// File: rtl/grad_accum.sv
`default_nettype none
// ============================================================================
// Module      : grad_accum
// Description : Accumulates N signed fixed-point gradient terms at extended
//               precision, then emits the saturated weight update
//               w_new = w - sum(terms) and holds it until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module grad_accum #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_w,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_term,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_w,
  output logic             o_sat,
  output logic             o_busy
);

  // Counter must hold N; one extra accumulator bit keeps w - acc in range.
  localparam int CNTW = $clog2(N + 1);
  localparam int ACCW = WIDTH + CNTW + 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_acc  = 2'd1;
  localparam logic [1:0] c_st_calc = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [CNTW-1:0] c_last = CNTW'(N - 1);

  // Largest / smallest WIDTH-bit signed values, sign-extended to ACCW.
  localparam logic signed [ACCW-1:0] c_sat_max =
    {{(ACCW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACCW-1:0] c_sat_min =
    {{(ACCW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  // Reject parameter sets the datapath is not sized for.
  if ((N < 1) || (N > 255) || (FRAC < 0) || (FRAC >= WIDTH)) begin : g_bad_params
    $error("grad_accum: illegal parameter set");
  end

  logic [1:0]             r_state;
  logic [CNTW-1:0]        r_cnt;
  logic signed [ACCW-1:0] r_acc;
  logic signed [ACCW-1:0] r_w;
  logic [WIDTH-1:0]       r_w_out;
  logic                   r_sat;

  logic                   w_accept;
  logic                   w_last;
  logic signed [ACCW-1:0] w_term_ext;
  logic signed [ACCW-1:0] w_diff;

  assign w_accept   = i_valid && (r_state == c_st_acc);
  assign w_last     = w_accept && (r_cnt == c_last);
  assign w_term_ext = {{(ACCW - WIDTH){i_term[WIDTH-1]}}, i_term};
  assign w_diff     = r_w - r_acc;

  // Moore outputs decoded from the state register.
  assign o_ready = (r_state == c_st_acc);
  assign o_valid = (r_state == c_st_done);
  assign o_busy  = (r_state != c_st_idle);
  assign o_w     = r_w_out;
  assign o_sat   = r_sat;

  // Control FSM: IDLE -> ACC (N accepts) -> CALC (one cycle) -> DONE (until ack).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: if (i_start) r_state <= c_st_acc;
        c_st_acc:  if (w_last)  r_state <= c_st_calc;
        c_st_calc: r_state <= c_st_done;
        c_st_done: if (i_ack)   r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  // Latch the weight on start, then accumulate each accepted term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if ((r_state == c_st_idle) && i_start) begin
      r_w   <= {{(ACCW - WIDTH){i_w[WIDTH-1]}}, i_w};
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= r_acc + w_term_ext;
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  // Saturate w - acc into WIDTH bits; result is held until the next CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_out <= '0;
      r_sat   <= 1'b0;
    end else if (r_state == c_st_calc) begin
      if (w_diff > c_sat_max) begin
        r_w_out <= c_sat_max[WIDTH-1:0];
        r_sat   <= 1'b1;
      end else if (w_diff < c_sat_min) begin
        r_w_out <= c_sat_min[WIDTH-1:0];
        r_sat   <= 1'b1;
      end else begin
        r_w_out <= w_diff[WIDTH-1:0];
        r_sat   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grad_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_grad_accum
// Description : Directed self-checking bench for grad_accum (N=4, Q8.24).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grad_accum;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [31:0] i_w;
  logic        i_valid;
  logic [31:0] i_term;
  logic        o_ready;
  logic        o_valid;
  logic        i_ack;
  logic [31:0] o_w;
  logic        o_sat;
  logic        o_busy;

  int vectors;
  int miscompares;
  int cyc;
  logic [31:0] held_w;

  grad_accum #(.WIDTH(32), .FRAC(24), .N(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_w     (i_w),
    .i_valid (i_valid),
    .i_term  (i_term),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ack   (i_ack),
    .o_w     (o_w),
    .o_sat   (o_sat),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_update(input logic [31:0] w);
    i_start = 1'b1;
    i_w     = w;
    step();
    i_start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] t, input int count);
    for (int k = 0; k < count; k++) begin
      i_valid = 1'b1;
      i_term  = t;
      step();
    end
    i_valid = 1'b0;
  endtask

  // Bounded wait for o_valid; a timeout shows up as a failed comparison.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, {31'd0, o_valid}, 32'd1);
  endtask

  task automatic ack();
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_w     = '0;
    i_valid = 1'b0;
    i_term  = '0;
    i_ack   = 1'b0;

    // ---- reset state
    step();
    step();
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy},  32'd0);
    chk("rst_w",     o_w,              32'h0000_0000);
    chk("rst_sat",   {31'd0, o_sat},   32'd0);
    rst_n = 1'b1;
    step();

    // ---- nominal: 1.0 - 4*0.25 = 0; o_valid 6 edges after the start edge
    start_update(32'h0100_0000);
    cyc = 1;
    chk("nom_busy",  {31'd0, o_busy},  32'd1);
    chk("nom_ready", {31'd0, o_ready}, 32'd1);
    feed(32'h0040_0000, 4);
    cyc = cyc + 4;
    chk("nom_calc_ready", {31'd0, o_ready}, 32'd0);
    chk("nom_calc_valid", {31'd0, o_valid}, 32'd0);
    while (!o_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("nom_latency", cyc, 32'd6);
    chk("nom_w",   o_w,            32'h0000_0000);
    chk("nom_sat", {31'd0, o_sat}, 32'd0);
    ack();
    chk("nom_ack_valid", {31'd0, o_valid}, 32'd0);
    chk("nom_ack_busy",  {31'd0, o_busy},  32'd0);

    // ---- positive saturation: 127 - 4*(-100) = 527
    start_update(32'h7F00_0000);
    feed(32'h9C00_0000, 4);
    wait_valid("psat_valid");
    chk("psat_w",   o_w,            32'h7FFF_FFFF);
    chk("psat_sat", {31'd0, o_sat}, 32'd1);
    ack();

    // ---- negative saturation: -128 - 4 = -132
    start_update(32'h8000_0000);
    feed(32'h0100_0000, 4);
    wait_valid("nsat_valid");
    chk("nsat_w",   o_w,            32'h8000_0000);
    chk("nsat_sat", {31'd0, o_sat}, 32'd1);
    ack();

    // ---- near-minimum without clipping: -128 + 4 = -124
    start_update(32'h8000_0000);
    feed(32'hFF00_0000, 4);
    wait_valid("nmin_valid");
    chk("nmin_w",   o_w,            32'h8400_0000);
    chk("nmin_sat", {31'd0, o_sat}, 32'd0);
    ack();

    // ---- handshake gaps: valid 1,0,0,1,1,0,1,1 with terms 1..8 -> 1+4+5+7
    start_update(32'h0000_0000);
    i_valid = 1'b1; i_term = 32'd1; step();
    i_valid = 1'b0; i_term = 32'd2; i_start = 1'b1; step();
    i_start = 1'b0; i_term = 32'd3; i_ack = 1'b1; step();
    i_ack = 1'b0;
    chk("gap_busy",  {31'd0, o_busy},  32'd1);
    chk("gap_ready", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1; i_term = 32'd4; step();
    i_valid = 1'b1; i_term = 32'd5; step();
    i_valid = 1'b0; i_term = 32'd6; step();
    i_valid = 1'b1; i_term = 32'd7; step();
    chk("gap_ready_after_nth", {31'd0, o_ready}, 32'd0);
    i_valid = 1'b1; i_term = 32'd8; step();
    i_valid = 1'b0;
    chk("gap_valid", {31'd0, o_valid}, 32'd1);
    chk("gap_w",     o_w,              32'hFFFF_FFEF);
    chk("gap_sat",   {31'd0, o_sat},   32'd0);

    // ---- hold: o_w stable and o_valid high for 10 cycles without ack
    held_w = o_w;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_valid", {31'd0, o_valid}, 32'd1);
      chk("hold_w",     o_w,              32'hFFFF_FFEF);
    end

    // ---- back-to-back: start with ack is ignored, start one cycle later runs
    i_ack   = 1'b1;
    i_start = 1'b1;
    i_w     = 32'h0100_0000;
    step();
    i_ack = 1'b0;
    chk("b2b_ack_busy", {31'd0, o_busy}, 32'd0);
    chk("b2b_keep_w",   o_w,             held_w);
    step();
    i_start = 1'b0;
    chk("b2b_busy",  {31'd0, o_busy},  32'd1);
    chk("b2b_ready", {31'd0, o_ready}, 32'd1);
    feed(32'h0010_0000, 4);
    wait_valid("b2b_valid");
    chk("b2b_w",   o_w,            32'h00C0_0000);
    chk("b2b_sat", {31'd0, o_sat}, 32'd0);
    ack();

    // ---- asynchronous reset after two accepted terms
    start_update(32'h0500_0000);
    feed(32'h0040_0000, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, o_ready}, 32'd0);
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_busy",  {31'd0, o_busy},  32'd0);
    chk("arst_w",     o_w,              32'h0000_0000);
    chk("arst_sat",   {31'd0, o_sat},   32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_idle_busy", {31'd0, o_busy}, 32'd0);
    start_update(32'h0100_0000);
    feed(32'h0040_0000, 4);
    wait_valid("restart_valid");
    chk("restart_w",   o_w,            32'h0000_0000);
    chk("restart_sat", {31'd0, o_sat}, 32'd0);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
